// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int FIFO_DEPTH  = 2;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int IMEM_ADDR_W = 5;
    localparam int INSTR_W     = 32;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]     data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry skid FIFO with synchronous flush and same-cycle push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  entry_t           i_data,
    input  logic             i_pop,
    output entry_t           o_head,
    output logic [CNT_W-1:0] o_count
);

    // Single-bit pointers: the depth is fixed at two entries.
    entry_t           r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && w_full && !i_pop));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem read per cycle, buffers
// returned words and hands them to decode over valid/ready.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W+1:0] instr_pc
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_issue_pc;
    logic              r_inflight;
    logic              r_inflight_epoch;
    logic              r_epoch;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_room;
    logic              w_valid;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occ;
    entry_t            w_push_entry;
    entry_t            w_head;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && instr_ready;

    // Occupancy once this cycle's response lands and any pop leaves.
    assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_room  = (w_occ < (CNT_W+1)'(FIFO_DEPTH));
    assign w_issue = (r_state == RUN) && fetch_en && !redirect_valid && w_room;

    assign w_push       = r_inflight && (r_inflight_epoch == r_epoch) && !redirect_valid;
    assign w_push_entry = '{pc: r_issue_pc, data: imem_data};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (fetch_en) w_state_nxt = RUN;
            RUN:     if (!fetch_en) w_state_nxt = r_inflight ? DRAIN : IDLE;
            DRAIN:   w_state_nxt = fetch_en ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_pc             <= RESET_PC;
            r_issue_pc       <= '0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issue_pc       <= r_pc;
                r_inflight_epoch <= r_epoch;
            end
            if (redirect_valid) begin
                r_pc    <= redirect_addr;
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr_data  = w_valid ? w_head.data : '0;
    assign instr_pc    = w_valid ? {w_head.pc, 2'b00} : '0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized + directed bench for imem_fetch_ctrl against a queue-based fetch model.
module tb_imem_fetch_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW+1:0] instr_pc;

    logic [DW-1:0] mem [32];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of word indices waiting for decode, one pending
    // read (-1 = none), the fetch PC and the mode (0 idle, 1 run, 2 drain).
    int q[$];
    int m_pc   = 0;
    int m_pend = -1;
    int m_mode = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_pc   = 0;
            m_pend = -1;
            m_mode = 0;
        end else begin
            bit pop, issue, had_pend;
            int occ;
            pop      = (q.size() > 0) && instr_ready;
            had_pend = (m_pend >= 0);
            occ      = q.size() + int'(had_pend) - int'(pop);
            issue    = (m_mode == 1) && fetch_en && !redirect_valid && (occ < 2);
            if (redirect_valid) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (had_pend) q.push_back(m_pend);
            end
            if (q.size() > 2) chk("model_overflow", 64'(q.size()), 64'd2);
            m_pend = issue ? m_pc : -1;
            if (redirect_valid) m_pc = int'(redirect_addr);
            else if (issue)     m_pc = (m_pc + 1) % 32;
            case (m_mode)
                0:       if (fetch_en) m_mode = 1;
                1:       if (!fetch_en) m_mode = had_pend ? 2 : 0;
                default: m_mode = fetch_en ? 1 : 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("valid", 64'(instr_valid), 64'(q.size() > 0));
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        if (q.size() > 0) begin
            chk("instr_pc", 64'(instr_pc), 64'(q[0] * 4));
            chk("instr_data", 64'(instr_data), 64'(mem[q[0]]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        logic [AW+1:0] hold_pc;
        logic [DW-1:0] hold_data;
        logic [AW-1:0] a0;
        logic [AW+1:0] wrap_exp [4];
        int n;

        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + DW'(k);
        wrap_exp[0] = 7'h78; wrap_exp[1] = 7'h7C; wrap_exp[2] = 7'h00; wrap_exp[3] = 7'h04;
        #1 rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_addr",  64'(imem_addr),   64'd0);
        chk("rst_pc",    64'(instr_pc),    64'd0);
        chk("rst_data",  64'(instr_data),  64'd0);

        // Stream from reset
        @(posedge clk); #1;
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        cyc(); cyc();
        chk("lat_not_yet", 64'(instr_valid), 64'd0);
        cyc();
        chk("lat_valid",  64'(instr_valid), 64'd1);
        chk("first_pc",   64'(instr_pc),    64'd0);
        chk("first_data", 64'(instr_data),  64'h1000_0000);
        cyc(); chk("second_pc", 64'(instr_pc), 64'h04);
        cyc(); chk("third_pc",  64'(instr_pc), 64'h08);
        repeat (3) cyc();

        // Backpressure
        instr_ready = 1'b0;
        hold_pc = instr_pc; hold_data = instr_data; a0 = imem_addr;
        repeat (5) begin
            cyc();
            chk("bp_pc",   64'(instr_pc),   64'(hold_pc));
            chk("bp_data", 64'(instr_data), 64'(hold_data));
        end
        chk("bp_addr_stall", 64'(imem_addr), 64'(a0));
        instr_ready = 1'b1;
        cyc();
        chk("bp_resume", 64'(instr_pc), 64'(hold_pc + 7'd4));
        repeat (3) cyc();

        // Redirect to word 20
        redirect_valid = 1'b1; redirect_addr = 5'd20;
        cyc();
        redirect_valid = 1'b0;
        wait_valid(n);
        chk("redir_valid", 64'(instr_valid), 64'd1);
        chk("redir_lat",   64'(n),           64'd2);
        chk("redir_pc",    64'(instr_pc),    64'h50);
        chk("redir_data",  64'(instr_data),  64'h1000_0014);
        repeat (2) cyc();

        // Wrap-around
        redirect_valid = 1'b1; redirect_addr = 5'd30;
        cyc();
        redirect_valid = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pc", 64'(instr_pc), 64'(wrap_exp[i]));
            cyc();
        end

        // Enable drop and resume
        fetch_en = 1'b0;
        repeat (6) cyc();
        chk("drop_idle_valid", 64'(instr_valid), 64'd0);
        a0 = imem_addr;
        repeat (3) cyc();
        chk("drop_addr_hold", 64'(imem_addr), 64'(a0));
        fetch_en = 1'b1;
        wait_valid(n);
        chk("resume_valid", 64'(instr_valid), 64'd1);
        chk("resume_pc",    64'(instr_pc),    64'({a0, 2'b00}));

        // Mid-operation reset under backpressure
        instr_ready = 1'b0;
        repeat (4) cyc();
        chk("bp2_valid", 64'(instr_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(instr_valid), 64'd0);
        chk("async_rst_addr",  64'(imem_addr),   64'd0);
        cyc();
        rst_n = 1'b1; instr_ready = 1'b1;
        wait_valid(n);
        chk("post_rst_valid", 64'(instr_valid), 64'd1);
        chk("post_rst_pc",    64'(instr_pc),    64'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = AW'($urandom);
            cyc();
        end
        redirect_valid = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
